// File: rtl/bus_status_sequencer_if.sv
// Host request/response handshake and bus-controller signals of the bus status sequencer.
// The master side is the host plus bus model; the slave side is the sequencer.
interface bus_status_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [19:0] req_address;
  logic [15:0] req_write_data;
  logic        resp_valid;
  logic [15:0] resp_read_data;
  logic        resp_timeout;
  logic [2:0]  processor_status;
  logic [19:0] bus_address;
  logic [15:0] bus_write_data;
  logic        bus_data_out_enable;
  logic [15:0] bus_read_data;
  logic        ready;

  modport master (
    output req_valid, req_type, req_address, req_write_data, bus_read_data, ready,
    input  req_ready, resp_valid, resp_read_data, resp_timeout, processor_status,
           bus_address, bus_write_data, bus_data_out_enable
  );

  modport slave (
    input  req_valid, req_type, req_address, req_write_data, bus_read_data, ready,
    output req_ready, resp_valid, resp_read_data, resp_timeout, processor_status,
           bus_address, bus_write_data, bus_data_out_enable
  );
endinterface

// File: rtl/bus_status_sequencer.sv
// Bus status sequencer: runs T-state bus cycles (TI/T1/T2/T3/TW/T4) for host requests and
// drives S2..S0 status, address and write data to an external bus controller.
module bus_status_sequencer #(
  parameter int unsigned TIMEOUT_WAITS = 15
) (
  input logic                   clock,
  input logic                   reset_n,
  bus_status_sequencer_if.slave bus
);

  localparam logic [7:0] WaitLimit = 8'(TIMEOUT_WAITS);
  localparam logic [2:0] TypeHalt  = 3'b011;
  localparam logic [2:0] TypeNull  = 3'b111;

  typedef enum logic [2:0] {StTi, StT1, StT2, StT3, StTw, StT4} state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        null_q, null_d;
  logic [7:0]  wait_q, wait_d;

  logic req_ready, accept, is_read, is_write, in_cycle;

  assign is_read   = type_q inside {3'b000, 3'b001, 3'b100, 3'b101};
  assign is_write  = type_q inside {3'b010, 3'b110};
  assign in_cycle  = state_q inside {StT1, StT2, StT3, StTw};
  assign req_ready = reset_n && ((state_q == StTi) || (state_q == StT4));
  assign accept    = bus.req_valid && req_ready;

  assign bus.req_ready           = req_ready;
  assign bus.processor_status    = in_cycle ? type_q : TypeNull;
  assign bus.bus_data_out_enable = is_write && (state_q inside {StT2, StT3, StTw, StT4});
  // A null request has no bus cycle; its response is the registered null_q pulse.
  assign bus.resp_valid          = (state_q == StT4) || null_q;
  assign bus.resp_timeout        = timeout_q;
  assign bus.resp_read_data      = rdata_q;
  assign bus.bus_address         = addr_q;
  assign bus.bus_write_data      = wdata_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    null_d    = 1'b0;

    unique case (state_q)
      StTi, StT4: begin
        state_d = StTi;
        if (accept) begin
          if (bus.req_type == TypeNull) begin
            null_d  = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StT1;
            type_d  = bus.req_type;
            addr_d  = bus.req_address;
            wdata_d = bus.req_write_data;
          end
        end
      end
      StT1: begin
        state_d = StT2;
        wait_d  = '0;
      end
      StT2: begin
        if (type_q == TypeHalt) begin
          state_d = StT4;
          rdata_d = '0;
        end else begin
          state_d = StT3;
        end
      end
      StT3, StTw: begin
        if (bus.ready) begin
          state_d = StT4;
          rdata_d = is_read ? bus.bus_read_data : '0;
        end else if ((state_q == StTw) && (wait_q == WaitLimit)) begin
          state_d   = StT4;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end else begin
          state_d = StTw;
          wait_d  = wait_q + 8'd1;
        end
      end
      default: state_d = StTi;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StTi;
      type_q    <= TypeNull;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      null_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      null_q    <= null_d;
    end
  end

endmodule

// File: tb/tb_bus_status_sequencer.sv
// Directed bench for bus_status_sequencer (TIMEOUT_WAITS = 3): a per-clock vector table
// plus hand sequences for back-to-back writes and reset during a wait state.
module tb_bus_status_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  bus_status_sequencer_if bif ();

  bus_status_sequencer #(
    .TIMEOUT_WAITS(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  typ;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] rdin;
    logic        rdy;
    logic        e_rr;
    logic [2:0]  e_st;
    logic        e_rv;
    logic [15:0] e_rd;
    logic        e_to;
    logic        e_oe;
    logic [19:0] e_ba;
    logic [15:0] e_bw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic vld, input logic [2:0] typ,
                              input logic [19:0] addr, input logic [15:0] wd,
                              input logic [15:0] rdin, input logic rdy, input logic e_rr,
                              input logic [2:0] e_st, input logic e_rv, input logic [15:0] e_rd,
                              input logic e_to, input logic e_oe, input logic [19:0] e_ba,
                              input logic [15:0] e_bw);
    vec_t v;
    v.rst = rst;   v.vld = vld;   v.typ = typ;   v.addr = addr; v.wd = wd;
    v.rdin = rdin; v.rdy = rdy;   v.e_rr = e_rr; v.e_st = e_st; v.e_rv = e_rv;
    v.e_rd = e_rd; v.e_to = e_to; v.e_oe = e_oe; v.e_ba = e_ba; v.e_bw = e_bw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n            = 1'b0;
    bif.req_valid      = 1'b0;
    bif.req_type       = 3'd0;
    bif.req_address    = '0;
    bif.req_write_data = '0;
    bif.bus_read_data  = '0;
    bif.ready          = 1'b0;

    // rst vld typ addr wd rdin rdy | rr st rv rd to oe ba bw
    vecs.push_back(mk(0,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd7,0,16'h0000,0,0,20'h00000,16'h0000));
    // mem read, zero waits
    vecs.push_back(mk(1,1,3'd5,20'h12345,16'h0000,16'h0000,1, 1,3'd7,0,16'h0000,0,0,20'h00000,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'h0000,0,0,20'h12345,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'h0000,0,0,20'h12345,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'hBEEF,1, 0,3'd5,0,16'h0000,0,0,20'h12345,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 1,3'd7,1,16'hBEEF,0,0,20'h12345,16'h0000));
    // mem read, ready held low -> forced termination after 3 TW
    vecs.push_back(mk(1,1,3'd5,20'h54321,16'h0000,16'h1111,0, 1,3'd7,0,16'hBEEF,0,0,20'h12345,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h2222,0, 0,3'd5,0,16'hBEEF,0,0,20'h54321,16'h0000));
    // timeout response; IO read accepted in the same T4
    vecs.push_back(mk(1,1,3'd1,20'h003F8,16'h0000,16'h0000,0, 1,3'd7,1,16'h0000,1,0,20'h54321,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,1, 0,3'd1,0,16'h0000,0,0,20'h003F8,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd1,0,16'h0000,0,0,20'h003F8,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'hDEAD,0, 0,3'd1,0,16'h0000,0,0,20'h003F8,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'hCAFE,1, 0,3'd1,0,16'h0000,0,0,20'h003F8,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 1,3'd7,1,16'hCAFE,0,0,20'h003F8,16'h0000));
    // IO write with two wait states
    vecs.push_back(mk(1,1,3'd2,20'h00ABC,16'hA55A,16'h0000,1, 1,3'd7,0,16'hCAFE,0,0,20'h003F8,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd2,0,16'hCAFE,0,0,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd2,0,16'hCAFE,0,1,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd2,0,16'hCAFE,0,1,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd2,0,16'hCAFE,0,1,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h7777,1, 0,3'd2,0,16'hCAFE,0,1,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 1,3'd7,1,16'h0000,0,1,20'h00ABC,16'hA55A));
    // INTA read, then halt accepted in T4, then null accepted in T4
    vecs.push_back(mk(1,1,3'd0,20'h00001,16'h0000,16'h0000,1, 1,3'd7,0,16'h0000,0,0,20'h00ABC,16'hA55A));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,1, 0,3'd0,0,16'h0000,0,0,20'h00001,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,1, 0,3'd0,0,16'h0000,0,0,20'h00001,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h1357,1, 0,3'd0,0,16'h0000,0,0,20'h00001,16'h0000));
    vecs.push_back(mk(1,1,3'd3,20'hFFFFF,16'hFFFF,16'h0000,0, 1,3'd7,1,16'h1357,0,0,20'h00001,16'h0000));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 0,3'd3,0,16'h1357,0,0,20'hFFFFF,16'hFFFF));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h9999,0, 0,3'd3,0,16'h1357,0,0,20'hFFFFF,16'hFFFF));
    vecs.push_back(mk(1,1,3'd7,20'h11111,16'h2222,16'h0000,0, 1,3'd7,1,16'h0000,0,0,20'hFFFFF,16'hFFFF));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 1,3'd7,1,16'h0000,0,0,20'hFFFFF,16'hFFFF));
    vecs.push_back(mk(1,0,3'd0,20'h00000,16'h0000,16'h0000,0, 1,3'd7,0,16'h0000,0,0,20'hFFFFF,16'hFFFF));

    foreach (vecs[i]) begin
      reset_n            = vecs[i].rst;
      bif.req_valid      = vecs[i].vld;
      bif.req_type       = vecs[i].typ;
      bif.req_address    = vecs[i].addr;
      bif.req_write_data = vecs[i].wd;
      bif.bus_read_data  = vecs[i].rdin;
      bif.ready          = vecs[i].rdy;
      @(negedge clock);
      n_vec++;
      check($sformatf("row%0d req_ready", i), 32'(bif.req_ready), 32'(vecs[i].e_rr));
      check($sformatf("row%0d status", i), 32'(bif.processor_status), 32'(vecs[i].e_st));
      check($sformatf("row%0d resp_valid", i), 32'(bif.resp_valid), 32'(vecs[i].e_rv));
      check($sformatf("row%0d resp_read_data", i), 32'(bif.resp_read_data), 32'(vecs[i].e_rd));
      check($sformatf("row%0d resp_timeout", i), 32'(bif.resp_timeout), 32'(vecs[i].e_to));
      check($sformatf("row%0d data_out_enable", i), 32'(bif.bus_data_out_enable),
            32'(vecs[i].e_oe));
      check($sformatf("row%0d bus_address", i), 32'(bif.bus_address), 32'(vecs[i].e_ba));
      check($sformatf("row%0d bus_write_data", i), 32'(bif.bus_write_data), 32'(vecs[i].e_bw));
      @(posedge clock);
      #1;
    end

    // Two mem writes with req_valid held: second accepted in T4, no TI in between
    bif.req_valid      = 1'b1;
    bif.req_type       = 3'd6;
    bif.req_address    = 20'h0A000;
    bif.req_write_data = 16'h1111;
    bif.ready          = 1'b1;
    @(negedge clock);
    n_vec++;
    check("b2b idle req_ready", 32'(bif.req_ready), 32'd1);
    @(posedge clock);
    #1;
    bif.req_address    = 20'h0B000;
    bif.req_write_data = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_vec++;
      check($sformatf("b2b%0d status", i), 32'(bif.processor_status),
            ((i % 4) == 3) ? 32'd7 : 32'd6);
      check($sformatf("b2b%0d resp_valid", i), 32'(bif.resp_valid),
            ((i % 4) == 3) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d data_out_enable", i), 32'(bif.bus_data_out_enable),
            ((i % 4) != 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d bus_address", i), 32'(bif.bus_address),
            (i < 4) ? 32'h0A000 : 32'h0B000);
      @(posedge clock);
      #1;
      if (i == 3) bif.req_valid = 1'b0;
    end

    // IO read stalled in TW, then reset asserted mid-cycle
    bif.req_valid   = 1'b1;
    bif.req_type    = 3'd1;
    bif.req_address = 20'h00300;
    bif.ready       = 1'b0;
    @(posedge clock);
    #1;
    bif.req_valid = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    n_vec++;
    check("tw status before reset", 32'(bif.processor_status), 32'd1);
    reset_n = 1'b0;
    #1;
    n_vec++;
    check("reset status", 32'(bif.processor_status), 32'd7);
    check("reset req_ready", 32'(bif.req_ready), 32'd0);
    check("reset resp_valid", 32'(bif.resp_valid), 32'd0);
    check("reset bus_address", 32'(bif.bus_address), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++;
      check($sformatf("post-reset%0d resp_valid", i), 32'(bif.resp_valid), 32'd0);
      check($sformatf("post-reset%0d req_ready", i), 32'(bif.req_ready), 32'd1);
      check($sformatf("post-reset%0d status", i), 32'(bif.processor_status), 32'd7);
      @(posedge clock);
      #1;
    end
    bif.req_valid   = 1'b1;
    bif.req_type    = 3'd5;
    bif.req_address = 20'h00777;
    @(posedge clock);
    #1;
    bif.req_valid = 1'b0;
    @(negedge clock);
    n_vec++;
    check("fresh T1 status", 32'(bif.processor_status), 32'd5);
    check("fresh T1 bus_address", 32'(bif.bus_address), 32'h00777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_status_sequencer.md
BUS_STATUS_SEQUENCER -- requirements
Module: bus_status_sequencer

Interface
REQ-001 Parameter: TIMEOUT_WAITS, default 15, meaning maximum TW states per bus cycle before forced termination (range 1..255).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  host requests a bus cycle.
REQ-005 req_ready  output  1  sequencer accepts the request this cycle.
REQ-006 req_type  input  3  status code to issue: 000 INTA, 001 IO read, 010 IO write, 011 halt, 100 code, 101 mem read, 110 mem write, 111 null.
REQ-007 req_address  input  20  cycle address.
REQ-008 req_write_data  input  16  write data.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_read_data  output  16  captured read data, valid with resp_valid.
REQ-011 resp_timeout  output  1  cycle was force-terminated, valid with resp_valid.
REQ-012 processor_status  output  3  S2..S0 to the bus controller; 111 = passive.
REQ-013 bus_address  output  20  registered address, held from T1 through T4.
REQ-014 bus_write_data  output  16  registered write data.
REQ-015 bus_data_out_enable  output  1  drive write data onto the bus.
REQ-016 bus_read_data  input  16  data from the bus.
REQ-017 ready  input  1  bus ready; low inserts wait states.

Function
REQ-018 States: TI, T1, T2, T3, TW, T4; one state per clock.
REQ-019 Handshake: transfer occurs on a rising edge with req_valid & req_ready; req_ready = 1 only in TI and T4, 0 while reset_n low.
REQ-020 Accept (types 000..110): next state T1; req_type, req_address and req_write_data registered on the same edge.
REQ-021 Accept of type 111: no bus cycle; state TI; resp_valid pulses next cycle with resp_read_data 0, resp_timeout 0.
REQ-022 processor_status = registered type in T1, T2, T3, TW; 111 in T4 and TI.
REQ-023 Transitions: T1->T2->T3; T3/TW -> T4 if ready = 1 at the edge, else -> TW; T4 -> T1 on accept, else TI.
REQ-024 Halt (011): T1->T2->T4; ready ignored; no data capture.
REQ-025 Wait counter: 8 bits, cleared in T1, incremented per TW entered; when it equals TIMEOUT_WAITS in TW with ready = 0, next state T4 with timeout flag set.
REQ-026 Read types (000, 001, 100, 101): bus_read_data captured into resp_read_data on the edge leaving T3/TW; timeout captures 0.
REQ-027 Write types (010, 110): bus_data_out_enable = 1 in T2, T3, TW, T4; 0 otherwise and for all other types.
REQ-028 resp_valid = 1 for exactly the T4 clock of each cycle; resp_timeout = 1 with it only on forced termination.
REQ-029 resp_read_data holds its value until the next capture; 0 after writes, halt and null.
REQ-030 Back-to-back: accept in T4 enters T1 next; minimum spacing one passive (T4) clock between status codes.
REQ-031 bus_address/bus_write_data hold last values in TI.
REQ-032 ready changes outside T3/TW have no effect.

Reset
REQ-033 reset_n low forces immediately: state TI, processor_status 111, resp_valid 0, resp_timeout 0, resp_read_data 0, bus_address 0, bus_write_data 0, bus_data_out_enable 0, wait counter 0.
REQ-034 Reset mid-cycle aborts the cycle; no resp_valid is produced for it; first accept after release starts a fresh T1.

Verification
REQ-035 Mem read 101, addr 0x12345, ready=1 -> status 101 for 3 clocks (T1-T3), 111 in T4; resp_valid in T4, resp_read_data = bus_read_data sampled at T3 end (0xBEEF).
REQ-036 IO write 010, data 0xA55A, ready low 2 clocks -> 2 TW states, status 010 for 5 clocks, bus_data_out_enable high 5 clocks (T2..T4), resp_timeout 0.
REQ-037 TIMEOUT_WAITS=3, mem read, ready held 0 -> exactly 3 TW, then T4, resp_valid with resp_timeout 1, resp_read_data 0.
REQ-038 Two mem writes with req_valid held -> second accepted in T4; status sequence 110,110,110,111,110,110,110,111; no TI between.
REQ-039 Halt 011 then null 111 -> halt: status 011 2 clocks, resp in T4; null: resp_valid next cycle, status stays 111.
REQ-040 reset_n low during TW of an IO read -> status 111 and req_ready 0 at once; no resp_valid; after release req_ready 1 in TI.
